seg7_scan_mux: RTL

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_scan_mux.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed hex 7-segment driver with dead time and PWM dimming.
// Ports:
//   CLK        - clock; all state updates on its rising edge
//   RST        - asynchronous active-high reset
//   value      - 4*DIGITS hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   dp         - DIGITS decimal points, bit i drives digit i
//   load       - captures value/dp into the pending register
//   brightness - PWM duty, 0 dimmest, 15 full
//   seg        - segments {a,b,c,d,e,f,g}, a is MSB
//   seg_dp     - decimal point segment
//   dig_en     - one-hot digit enable
//   frame_done - one-cycle pulse after the last digit of each scan
// Optional feature: define SEG7_LZS_EN to blank leading-zero digits.
module seg7_scan_mux #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 64,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int EN_ACTIVE_LOW  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic [3:0]            brightness,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
    localparam logic DP_OFF = SEG_ACTIVE_LOW != 0;
    localparam logic [DIGITS-1:0] EN_OFF = EN_ACTIVE_LOW != 0 ? '1 : '0;
    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [15:0]         phase, phase_n;
    logic [3:0]          pwm;
    logic [4*DIGITS-1:0] pend_val, disp_val;
    logic [DIGITS-1:0]   pend_dp, disp_dp;
    logic                wrap, frame_evt;
    logic [3:0]          nib;
    logic                lz, lit, dp_c;
    logic [6:0]          seg_c;
    logic [DIGITS-1:0]   en_c;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        phase_n = phase + 16'd1;
        wrap    = 1'b0;
        if (state == BLANK) begin
            if (BLANK_CYCLES == 0 || phase == 16'(BLANK_CYCLES - 1)) begin
                state_n = DRIVE;
                phase_n = '0;
            end
        end else if (phase == 16'(SCAN_DIV - 1)) begin
            // with no dead time the next digit is driven straight away
            state_n = BLANK_CYCLES == 0 ? DRIVE : BLANK;
            phase_n = '0;
            wrap    = idx == IW'(DIGITS - 1);
            idx_n   = wrap ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= BLANK;
            idx       <= '0;
            phase     <= '0;
            pwm       <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            disp_val  <= '0;
            disp_dp   <= '0;
            frame_evt <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            phase     <= phase_n;
            pwm       <= pwm + 4'd1;
            frame_evt <= wrap;
            if (load) {pend_val, pend_dp} <= {value, dp};
            // a load coinciding with the wrap goes straight to the display
            if (wrap) {disp_val, disp_dp} <= load ? {value, dp} : {pend_val, pend_dp};
        end
    end

    always_comb begin
        nib = disp_val[{idx, 2'b00} +: 4];
`ifdef SEG7_LZS_EN
        // blank when this nibble and every higher one is zero
        lz = idx != '0 && (disp_val >> {idx, 2'b00}) == '0;
`else
        lz = 1'b0;
`endif
        lit   = state == DRIVE && pwm <= brightness;
        seg_c = lit && !lz ? HEX[nib] : 7'h00;
        dp_c  = lit && disp_dp[idx];
        en_c  = state == DRIVE ? DIGITS'(1) << idx : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg        <= SEG_OFF;
            seg_dp     <= DP_OFF;
            dig_en     <= EN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_c ^ SEG_OFF;
            seg_dp     <= dp_c ^ DP_OFF;
            dig_en     <= en_c ^ EN_OFF;
            frame_done <= frame_evt;
        end
    end
endmodule
